// File: rtl/pipeline_ctrl_pkg.sv
// Shared constants for the pipeline stall/flush sequencer.
//   - FSM state encodings
//   - flush down-counter width
//   - event priority ranking (0 = highest)
package pipeline_ctrl_pkg;

    // Width of the post-redirect flush down-counter (FLUSH_CYCLES <= 15)
    localparam int unsigned FCNT_W = 4;

    typedef enum logic {
        CTRL_RUN   = 1'b0,
        CTRL_FLUSH = 1'b1
    } ctrl_state_e;

    // Event priority, highest first: a cache freeze masks everything, a
    // redirect kills S1 so it masks the flush shadow and any load-use bubble.
    localparam int unsigned PRIO_FREEZE   = 0;
    localparam int unsigned PRIO_REDIRECT = 1;
    localparam int unsigned PRIO_FLUSH    = 2;
    localparam int unsigned PRIO_BUBBLE   = 3;

endpackage

// File: rtl/pipeline_ctrl_perf_counter.sv
// Free-running enabled event counter, wraps modulo 2^CNT_W.
//   clk, rst (sync, active-low), en (count this cycle), count (current value)
module perf_counter #(
    parameter int unsigned CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    output logic [CNT_W-1:0] count
);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    // Next-count logic
    always_comb begin
        count_d = count_q;
        if (en) begin
            count_d = count_q + CNT_W'(1);
        end
    end

    // Count register
    always_ff @(posedge clk) begin
        if (!rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/pipeline_ctrl.sv
// Stall/flush sequencer for the 3-stage core (S1 fetch/decode-read,
// S2 execute, S3 memory/writeback).
//   Inputs : clk, rst (sync, active-low), icache_stall, dcache_stall,
//            dr_bubble (load-use), s2_redirect (taken branch/jump in S2)
//   Outputs: stall_pc, stall_s1, stall_s23, flush_s1, flush_s2, pc_redirect
//            (zero-latency, from state + current inputs);
//            stall_cnt, bubble_cnt, flush_cnt (registered perf counters)
module pipeline_ctrl
    import pipeline_ctrl_pkg::*;
#(
    parameter int unsigned FLUSH_CYCLES = 1,
    parameter int unsigned CNT_W        = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             icache_stall,
    input  logic             dcache_stall,
    input  logic             dr_bubble,
    input  logic             s2_redirect,
    output logic             stall_pc,
    output logic             stall_s1,
    output logic             stall_s23,
    output logic             flush_s1,
    output logic             flush_s2,
    output logic             pc_redirect,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] bubble_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    ctrl_state_e       state_q;
    ctrl_state_e       state_d;
    logic [FCNT_W-1:0] fcnt_q;
    logic [FCNT_W-1:0] fcnt_d;
    logic              freeze_c;
    logic              stall_en_c;
    logic              bubble_en_c;
    logic              flush_en_c;

    assign freeze_c = icache_stall | dcache_stall;

    // Priority resolution: freeze > redirect > flush shadow > load-use bubble
    always_comb begin
        state_d     = state_q;
        fcnt_d      = fcnt_q;
        stall_pc    = 1'b0;
        stall_s1    = 1'b0;
        stall_s23   = 1'b0;
        flush_s1    = 1'b0;
        flush_s2    = 1'b0;
        pc_redirect = 1'b0;
        stall_en_c  = 1'b0;
        bubble_en_c = 1'b0;
        flush_en_c  = 1'b0;

        if (!rst) begin
            state_d = CTRL_RUN;
            fcnt_d  = '0;
        end else if (freeze_c) begin
            // Whole pipe holds; FSM and flush counter are frozen too
            stall_pc   = 1'b1;
            stall_s1   = 1'b1;
            stall_s23  = 1'b1;
            stall_en_c = 1'b1;
        end else if (s2_redirect) begin
            // Bubble request is moot: the instruction that raised it is killed
            pc_redirect = 1'b1;
            flush_s1    = 1'b1;
            flush_en_c  = 1'b1;
            if (FLUSH_CYCLES > 1) begin
                state_d = CTRL_FLUSH;
                fcnt_d  = FCNT_W'(FLUSH_CYCLES - 1);
            end else begin
                state_d = CTRL_RUN;
                fcnt_d  = '0;
            end
        end else if (state_q == CTRL_FLUSH) begin
            // Fetch-latency shadow: whatever arrives in S1 is stale
            flush_s1 = 1'b1;
            if (fcnt_q == FCNT_W'(1)) begin
                state_d = CTRL_RUN;
                fcnt_d  = '0;
            end else begin
                fcnt_d = fcnt_q - FCNT_W'(1);
            end
        end else if (dr_bubble) begin
            stall_pc    = 1'b1;
            stall_s1    = 1'b1;
            flush_s2    = 1'b1;
            bubble_en_c = 1'b1;
        end
    end

    // FSM state and flush down-counter
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= CTRL_RUN;
            fcnt_q  <= '0;
        end else begin
            state_q <= state_d;
            fcnt_q  <= fcnt_d;
        end
    end

    perf_counter #(.CNT_W(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .rst   (rst),
        .en    (stall_en_c),
        .count (stall_cnt)
    );

    perf_counter #(.CNT_W(CNT_W)) u_bubble_cnt (
        .clk   (clk),
        .rst   (rst),
        .en    (bubble_en_c),
        .count (bubble_cnt)
    );

    perf_counter #(.CNT_W(CNT_W)) u_flush_cnt (
        .clk   (clk),
        .rst   (rst),
        .en    (flush_en_c),
        .count (flush_cnt)
    );

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Directed bench for pipeline_ctrl. Two instances share the stimulus:
//   u_f3 : FLUSH_CYCLES = 3, CNT_W = 32
//   u_f1 : FLUSH_CYCLES = 1, CNT_W = 4 (bubble and wrap checks)
// Control vector order: {stall_pc, stall_s1, stall_s23, flush_s1, flush_s2, pc_redirect}
module tb_pipeline_ctrl;

    logic clk = 1'b0;
    logic rst;
    logic icache_stall;
    logic dcache_stall;
    logic dr_bubble;
    logic s2_redirect;

    logic        f3_stall_pc, f3_stall_s1, f3_stall_s23, f3_flush_s1, f3_flush_s2, f3_pc_redirect;
    logic [31:0] f3_stall_cnt, f3_bubble_cnt, f3_flush_cnt;
    logic        f1_stall_pc, f1_stall_s1, f1_stall_s23, f1_flush_s1, f1_flush_s2, f1_pc_redirect;
    logic [3:0]  f1_stall_cnt, f1_bubble_cnt, f1_flush_cnt;

    logic [5:0] ctl3;
    logic [5:0] ctl1;

    int n_cmp = 0;
    int n_bad = 0;

    localparam logic [5:0] C_IDLE   = 6'b000000;
    localparam logic [5:0] C_FREEZE = 6'b111000;
    localparam logic [5:0] C_BUBBLE = 6'b110010;
    localparam logic [5:0] C_REDIR  = 6'b000101;
    localparam logic [5:0] C_FLUSH  = 6'b000100;

    always #5 clk = ~clk;

    assign ctl3 = {f3_stall_pc, f3_stall_s1, f3_stall_s23, f3_flush_s1, f3_flush_s2, f3_pc_redirect};
    assign ctl1 = {f1_stall_pc, f1_stall_s1, f1_stall_s23, f1_flush_s1, f1_flush_s2, f1_pc_redirect};

    pipeline_ctrl #(.FLUSH_CYCLES(3), .CNT_W(32)) u_f3 (
        .clk          (clk),
        .rst          (rst),
        .icache_stall (icache_stall),
        .dcache_stall (dcache_stall),
        .dr_bubble    (dr_bubble),
        .s2_redirect  (s2_redirect),
        .stall_pc     (f3_stall_pc),
        .stall_s1     (f3_stall_s1),
        .stall_s23    (f3_stall_s23),
        .flush_s1     (f3_flush_s1),
        .flush_s2     (f3_flush_s2),
        .pc_redirect  (f3_pc_redirect),
        .stall_cnt    (f3_stall_cnt),
        .bubble_cnt   (f3_bubble_cnt),
        .flush_cnt    (f3_flush_cnt)
    );

    pipeline_ctrl #(.FLUSH_CYCLES(1), .CNT_W(4)) u_f1 (
        .clk          (clk),
        .rst          (rst),
        .icache_stall (icache_stall),
        .dcache_stall (dcache_stall),
        .dr_bubble    (dr_bubble),
        .s2_redirect  (s2_redirect),
        .stall_pc     (f1_stall_pc),
        .stall_s1     (f1_stall_s1),
        .stall_s23    (f1_stall_s23),
        .flush_s1     (f1_flush_s1),
        .flush_s2     (f1_flush_s2),
        .pc_redirect  (f1_pc_redirect),
        .stall_cnt    (f1_stall_cnt),
        .bubble_cnt   (f1_bubble_cnt),
        .flush_cnt    (f1_flush_cnt)
    );

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Apply one cycle of inputs at the falling edge; outputs are sampled 1 ns later
    task automatic drive(input logic r, input logic ic, input logic dc,
                         input logic bub, input logic red);
        @(negedge clk);
        rst          = r;
        icache_stall = ic;
        dcache_stall = dc;
        dr_bubble    = bub;
        s2_redirect  = red;
        #1;
    endtask

    task automatic check_ctl(input string tag, input logic [5:0] e3, input logic [5:0] e1);
        check_eq({tag, "_ctl3"}, 32'(ctl3), 32'(e3));
        check_eq({tag, "_ctl1"}, 32'(ctl1), 32'(e1));
    endtask

    initial begin
        rst = 1'b0; icache_stall = 1'b0; dcache_stall = 1'b0;
        dr_bubble = 1'b0; s2_redirect = 1'b0;

        // Reset held 3 cycles with every input high
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 1'b1, 1'b1, 1'b1, 1'b1);
            check_ctl("rst_hold", C_IDLE, C_IDLE);
        end
        check_eq("rst_stall3",  f3_stall_cnt,       32'd0);
        check_eq("rst_bubble3", f3_bubble_cnt,      32'd0);
        check_eq("rst_flush3",  f3_flush_cnt,       32'd0);
        check_eq("rst_bubble1", 32'(f1_bubble_cnt), 32'd0);

        // Release: outputs follow inputs in the same cycle (freeze wins)
        drive(1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
        check_ctl("rst_release", C_FREEZE, C_FREEZE);
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        check_ctl("idle0", C_IDLE, C_IDLE);
        check_eq("stall3_a", f3_stall_cnt, 32'd1);

        // Single load-use bubble
        drive(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        check_ctl("bubble", C_BUBBLE, C_BUBBLE);
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        check_ctl("bubble_end", C_IDLE, C_IDLE);
        check_eq("bubble1_a", 32'(f1_bubble_cnt), 32'd1);
        check_eq("bubble3_a", f3_bubble_cnt,      32'd1);

        // Redirect with dr_bubble held high through the flush shadow
        drive(1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
        check_ctl("redir", C_REDIR, C_REDIR);
        drive(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        check_ctl("redir_sh1", C_FLUSH, C_BUBBLE);
        drive(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        check_ctl("redir_sh2", C_FLUSH, C_BUBBLE);
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        check_ctl("redir_end", C_IDLE, C_IDLE);
        check_eq("flush3_a",  f3_flush_cnt,       32'd1);
        check_eq("bubble3_b", f3_bubble_cnt,      32'd1);
        check_eq("bubble1_b", 32'(f1_bubble_cnt), 32'd3);

        // Freeze in the middle of the flush shadow
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        check_ctl("mf_redir", C_REDIR, C_REDIR);
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        check_ctl("mf_sh1", C_FLUSH, C_IDLE);
        drive(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        check_ctl("mf_frz1", C_FREEZE, C_FREEZE);
        drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        check_ctl("mf_frz2", C_FREEZE, C_FREEZE);
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        check_ctl("mf_sh2", C_FLUSH, C_IDLE);
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        check_ctl("mf_end", C_IDLE, C_IDLE);
        check_eq("stall3_b", f3_stall_cnt, 32'd3);
        check_eq("flush3_b", f3_flush_cnt, 32'd2);

        // Priority: freeze masks a simultaneous redirect and bubble
        drive(1'b1, 1'b0, 1'b1, 1'b1, 1'b1);
        check_ctl("prio_frz", C_FREEZE, C_FREEZE);
        drive(1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
        check_ctl("prio_redir", C_REDIR, C_REDIR);
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        check_ctl("prio_sh1", C_FLUSH, C_IDLE);
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        check_ctl("prio_sh2", C_FLUSH, C_IDLE);
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        check_ctl("prio_end", C_IDLE, C_IDLE);
        check_eq("bubble3_c", f3_bubble_cnt,      32'd1);
        check_eq("flush3_c",  f3_flush_cnt,       32'd3);
        check_eq("stall3_c",  f3_stall_cnt,       32'd4);
        check_eq("flush1_c",  32'(f1_flush_cnt),  32'd3);
        check_eq("bubble1_c", 32'(f1_bubble_cnt), 32'd3);

        // Reset in mid-flush abandons the shadow
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        check_ctl("rf_redir", C_REDIR, C_REDIR);
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        check_ctl("rf_rst", C_IDLE, C_IDLE);
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        check_ctl("rf_after", C_IDLE, C_IDLE);
        check_eq("rf_flush3", f3_flush_cnt, 32'd0);
        check_eq("rf_stall3", f3_stall_cnt, 32'd0);

        // 17 bubble pulses wrap the 4-bit counter to 1
        for (int i = 0; i < 17; i++) begin
            drive(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
            drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        end
        check_eq("wrap_bubble1", 32'(f1_bubble_cnt), 32'd1);
        check_eq("wrap_bubble3", f3_bubble_cnt,      32'd17);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
